// File: rtl/pipe_pkg.sv
// Shared definitions for the RV64I pipeline control logic: controller state
// encoding, register-file index defaults and the zero-register constant.
package pipe_pkg;

    localparam int RF_SIZE_DEF = 5;
    localparam logic [RF_SIZE_DEF-1:0] REG_ZERO = '0;

    // Width of the data-memory wait counter; MEM_TIMEOUT must fit in it.
    localparam int WAIT_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DROP    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX_VAL; synchronous clear wins over increment,
// asynchronous active-high reset.
module sat_counter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != MAX_VAL)) begin
            cnt_o <= cnt_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory freezes and EX
// redirects (with stale-fetch discard), plus stall/flush counters and timeout.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RF_SIZE     = RF_SIZE_DEF,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RF_SIZE-1:0]   id_rs1_i,
    input  logic [RF_SIZE-1:0]   id_rs2_i,
    input  logic                 id_ers1_i,
    input  logic                 id_ers2_i,
    input  logic [RF_SIZE-1:0]   ex_rd_i,
    input  logic                 ex_erd_i,
    input  logic                 ex_memread_i,
    input  logic                 redirect_i,
    input  logic                 imem_pending_i,
    input  logic                 imem_ack_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ack_i,
    output logic                 stall_pc_o,
    output logic                 stall_ifid_o,
    output logic                 flush_ifid_o,
    output logic                 stall_idex_o,
    output logic                 flush_idex_o,
    output logic                 stall_exmem_o,
    output logic                 flush_memwb_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic                 mem_timeout_o
);

    localparam logic [RF_SIZE-1:0] RD_ZERO  = RF_SIZE'(REG_ZERO);
    localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic              memwait;
    logic              loaduse;
    logic              redirect_take;
    logic              wait_inc;
    logic              wait_hit;
    logic [WAIT_W-1:0] wait_cnt;

    // Data-memory handshake: dmem_req_i stays high while MEM holds a request;
    // the request completes in the cycle dmem_ack_i is high (no separate ready).
    assign memwait = dmem_req_i & ~dmem_ack_i;

    assign loaduse = ex_memread_i & ex_erd_i & (ex_rd_i != RD_ZERO) &
                     ((id_ers1_i & (id_rs1_i == ex_rd_i)) |
                      (id_ers2_i & (id_rs2_i == ex_rd_i)));

    // A redirect is deferred while memory freezes EX; it re-presents later.
    assign redirect_take = redirect_i & ~memwait & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_pc_o    = 1'b0;
        stall_ifid_o  = 1'b0;
        flush_ifid_o  = 1'b0;
        stall_idex_o  = 1'b0;
        flush_idex_o  = 1'b0;
        stall_exmem_o = 1'b0;
        flush_memwb_o = 1'b0;

        // Strobes stay quiet while reset is asserted, whatever the inputs do.
        if (!rst_i) begin
            if (memwait) begin
                stall_pc_o    = 1'b1;
                stall_ifid_o  = 1'b1;
                stall_idex_o  = 1'b1;
                stall_exmem_o = 1'b1;
                flush_memwb_o = 1'b1;
            end else if (redirect_i) begin
                flush_ifid_o  = 1'b1;
                flush_idex_o  = 1'b1;
            end else if (loaduse) begin
                stall_pc_o    = 1'b1;
                stall_ifid_o  = 1'b1;
                flush_idex_o  = 1'b1;
            end
            if (state_q == DROP) begin
                flush_ifid_o  = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (memwait) begin
                    state_d = MEMWAIT;
                end else if (redirect_i && imem_pending_i && !imem_ack_i) begin
                    state_d = DROP;
                end
            end
            MEMWAIT: begin
                if (dmem_ack_i) begin
                    state_d = (redirect_i && imem_pending_i && !imem_ack_i) ? DROP : RUN;
                end
            end
            DROP: begin
                // The frozen front end keeps the stale fetch until memory is done.
                if (!memwait && imem_ack_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Wait length counts consecutive unacknowledged data-memory cycles.
    assign wait_inc = (state_q == MEMWAIT) ? ~dmem_ack_i : memwait;
    assign wait_hit = wait_inc & (wait_cnt == (WAIT_MAX - WAIT_W'(1)));

    sat_counter #(
        .WIDTH   (WAIT_W),
        .MAX_VAL (WAIT_MAX)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~wait_inc),
        .inc_i (wait_inc),
        .cnt_o (wait_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_timeout_o <= 1'b0;
        end else if (wait_hit) begin
            mem_timeout_o <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (stall_pc_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (redirect_take),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: hand-derived expected output vectors are
// queued as each cycle's stimulus is driven and compared at the falling edge.
module tb_hazard_ctrl;

    localparam int RF  = 5;
    localparam int CW  = 2;
    localparam int MTO = 4;

    // Strobe order: stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
    // stall_exmem, flush_memwb.
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_FRZ  = 7'b1101011;
    localparam logic [6:0] S_LU   = 7'b1100100;
    localparam logic [6:0] S_RD   = 7'b0010100;
    localparam logic [6:0] S_DRP  = 7'b0010000;
    localparam logic [6:0] S_FDRP = 7'b1111011;

    typedef struct packed {
        logic [RF-1:0] rs1;
        logic [RF-1:0] rs2;
        logic          ers1;
        logic          ers2;
        logic [RF-1:0] rd;
        logic          erd;
        logic          memread;
        logic          redirect;
        logic          ipend;
        logic          iack;
        logic          dreq;
        logic          dack;
    } in_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RF-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_ers1, id_ers2, ex_erd, ex_memread, redirect;
    logic          imem_pending, imem_ack, dmem_req, dmem_ack;
    logic          stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex;
    logic          stall_exmem, flush_memwb, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [11:0]   obs;

    logic [11:0]   exp_q[$];
    string         tag_q[$];
    logic [11:0]   mon_exp;
    string         mon_tag;
    int            n_checks = 0;
    int            n_errors = 0;
    in_t           v;
    logic [RF-1:0] r;

    hazard_ctrl #(
        .RF_SIZE     (RF),
        .CNT_WIDTH   (CW),
        .MEM_TIMEOUT (MTO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_ers1_i      (id_ers1),
        .id_ers2_i      (id_ers2),
        .ex_rd_i        (ex_rd),
        .ex_erd_i       (ex_erd),
        .ex_memread_i   (ex_memread),
        .redirect_i     (redirect),
        .imem_pending_i (imem_pending),
        .imem_ack_i     (imem_ack),
        .dmem_req_i     (dmem_req),
        .dmem_ack_i     (dmem_ack),
        .stall_pc_o     (stall_pc),
        .stall_ifid_o   (stall_ifid),
        .flush_ifid_o   (flush_ifid),
        .stall_idex_o   (stall_idex),
        .flush_idex_o   (flush_idex),
        .stall_exmem_o  (stall_exmem),
        .flush_memwb_o  (flush_memwb),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .mem_timeout_o  (mem_timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign obs = {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
                  stall_exmem, flush_memwb, mem_timeout, stall_cnt, flush_cnt};

    function automatic logic [11:0] mk(input logic [6:0] s, input logic to,
                                       input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        return {s, to, sc, fc};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input in_t x);
        id_rs1       = x.rs1;
        id_rs2       = x.rs2;
        id_ers1      = x.ers1;
        id_ers2      = x.ers2;
        ex_rd        = x.rd;
        ex_erd       = x.erd;
        ex_memread   = x.memread;
        redirect     = x.redirect;
        imem_pending = x.ipend;
        imem_ack     = x.iack;
        dmem_req     = x.dreq;
        dmem_ack     = x.dack;
    endtask

    task automatic drive(input string tag, input in_t x, input logic [11:0] e);
        @(posedge clk);
        #1;
        apply(x);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases after an edge.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(tag, 32'(obs), 32'(mk(S_NONE, 1'b0, '0, '0)));
        apply('0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            check(mon_tag, 32'(obs), 32'(mon_exp));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        apply('0);
        #2;
        check("reset_state", 32'(obs), 32'(mk(S_NONE, 1'b0, '0, '0)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use detection
        v = '0;
        drive("idle_run", v, mk(S_NONE, 0, 2'd0, 2'd0));
        v = '0; v.memread = 1; v.erd = 1; v.rd = 5; v.ers1 = 1; v.rs1 = 5;
        drive("lu_rs1", v, mk(S_LU, 0, 2'd0, 2'd0));
        v = '0;
        drive("lu_after", v, mk(S_NONE, 0, 2'd1, 2'd0));
        v = '0; v.memread = 1; v.erd = 1; v.rd = 0; v.ers1 = 1; v.rs1 = 0;
        drive("lu_x0", v, mk(S_NONE, 0, 2'd1, 2'd0));
        v = '0; v.memread = 1; v.erd = 1; v.rd = 7; v.ers1 = 1; v.rs1 = 3; v.ers2 = 1; v.rs2 = 7;
        drive("lu_rs2", v, mk(S_LU, 0, 2'd1, 2'd0));
        v = '0; v.memread = 1; v.erd = 1; v.rd = 5; v.ers1 = 0; v.rs1 = 5;
        drive("lu_noers", v, mk(S_NONE, 0, 2'd2, 2'd0));
        v = '0; v.memread = 0; v.erd = 1; v.rd = 5; v.ers1 = 1; v.rs1 = 5;
        drive("lu_noload", v, mk(S_NONE, 0, 2'd2, 2'd0));
        reset_mid("rst_a");

        // Random load-use matches; stall count saturates at 3
        for (int i = 0; i < 4; i++) begin
            r = RF'($urandom_range(1, 31));
            v = '0; v.memread = 1; v.erd = 1; v.rd = r; v.ers1 = 1; v.rs1 = r;
            drive("lu_rand", v, mk(S_LU, 0, CW'(i), 2'd0));
        end
        r = RF'($urandom_range(1, 31));
        v = '0; v.memread = 1; v.erd = 1; v.rd = r; v.ers1 = 1; v.rs1 = r ^ RF'($urandom_range(1, 31));
        drive("lu_rand_miss", v, mk(S_NONE, 0, 2'd3, 2'd0));
        reset_mid("rst_b");

        // Data-memory wait of three cycles
        v = '0; v.dreq = 1;
        drive("dw_1", v, mk(S_FRZ, 0, 2'd0, 2'd0));
        drive("dw_2", v, mk(S_FRZ, 0, 2'd1, 2'd0));
        drive("dw_3", v, mk(S_FRZ, 0, 2'd2, 2'd0));
        v.dack = 1;
        drive("dw_ack", v, mk(S_NONE, 0, 2'd3, 2'd0));
        v = '0;
        drive("dw_done", v, mk(S_NONE, 0, 2'd3, 2'd0));
        reset_mid("rst_c");

        // Redirect with a pending fetch, then a second redirect inside DROP
        v = '0; v.redirect = 1; v.ipend = 1;
        drive("rd_1", v, mk(S_RD, 0, 2'd0, 2'd0));
        v = '0; v.ipend = 1;
        drive("drop_1", v, mk(S_DRP, 0, 2'd0, 2'd1));
        v.iack = 1;
        drive("drop_ack", v, mk(S_DRP, 0, 2'd0, 2'd1));
        v = '0;
        drive("rd_run", v, mk(S_NONE, 0, 2'd0, 2'd1));
        v = '0; v.redirect = 1;
        drive("rd_nopend", v, mk(S_RD, 0, 2'd0, 2'd1));
        v = '0;
        drive("rd_nopend_run", v, mk(S_NONE, 0, 2'd0, 2'd2));
        v = '0; v.redirect = 1; v.ipend = 1;
        drive("rd_2", v, mk(S_RD, 0, 2'd0, 2'd2));
        drive("rd_in_drop", v, mk(S_RD, 0, 2'd0, 2'd3));
        v = '0; v.ipend = 1;
        drive("drop_2", v, mk(S_DRP, 0, 2'd0, 2'd3));
        v.iack = 1;
        drive("drop_ack2", v, mk(S_DRP, 0, 2'd0, 2'd3));
        v = '0;
        drive("fcnt_sat", v, mk(S_NONE, 0, 2'd0, 2'd3));
        reset_mid("rst_d");

        // Priority: memwait beats redirect beats load-use
        v = '0; v.redirect = 1; v.dreq = 1; v.memread = 1; v.erd = 1; v.rd = 9; v.ers1 = 1; v.rs1 = 9;
        drive("pri_1", v, mk(S_FRZ, 0, 2'd0, 2'd0));
        drive("pri_2", v, mk(S_FRZ, 0, 2'd1, 2'd0));
        v.dack = 1;
        drive("pri_ack", v, mk(S_RD, 0, 2'd2, 2'd0));
        v = '0;
        drive("pri_done", v, mk(S_NONE, 0, 2'd2, 2'd1));
        reset_mid("rst_e");

        // Timeout after four wait cycles, sticky past the ack
        v = '0; v.dreq = 1;
        drive("to_1", v, mk(S_FRZ, 0, 2'd0, 2'd0));
        drive("to_2", v, mk(S_FRZ, 0, 2'd1, 2'd0));
        drive("to_3", v, mk(S_FRZ, 0, 2'd2, 2'd0));
        drive("to_4", v, mk(S_FRZ, 0, 2'd3, 2'd0));
        drive("to_5", v, mk(S_FRZ, 1, 2'd3, 2'd0));
        drive("to_6", v, mk(S_FRZ, 1, 2'd3, 2'd0));
        v.dack = 1;
        drive("to_ack", v, mk(S_NONE, 1, 2'd3, 2'd0));
        v = '0;
        drive("to_sticky", v, mk(S_NONE, 1, 2'd3, 2'd0));
        v = '0; v.dreq = 1;
        drive("to_rewait", v, mk(S_FRZ, 1, 2'd3, 2'd0));
        reset_mid("rst_midwait");
        v = '0;
        drive("after_rst_wait", v, mk(S_NONE, 0, 2'd0, 2'd0));

        // Reset in DROP abandons the drop
        v = '0; v.redirect = 1; v.ipend = 1;
        drive("rd_pre_rst", v, mk(S_RD, 0, 2'd0, 2'd0));
        reset_mid("rst_middrop");
        v = '0; v.ipend = 1;
        drive("after_rst_drop", v, mk(S_NONE, 0, 2'd0, 2'd0));

        // Memory freeze inside DROP keeps the drop armed
        v = '0; v.redirect = 1; v.ipend = 1;
        drive("dm_rd", v, mk(S_RD, 0, 2'd0, 2'd0));
        v = '0; v.dreq = 1; v.ipend = 1;
        drive("dm_frz", v, mk(S_FDRP, 0, 2'd0, 2'd1));
        v = '0; v.dreq = 1; v.dack = 1; v.ipend = 1; v.iack = 1;
        drive("dm_ack", v, mk(S_DRP, 0, 2'd1, 2'd1));
        v = '0;
        drive("dm_done", v, mk(S_NONE, 0, 2'd1, 2'd1));

        @(posedge clk);
        @(negedge clk);
        #1;
        check("q_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
